// File: rtl/tmr_unit_pkg.sv
// Shared timer definitions: control-word field positions, FSM state encoding and sizes.
package tmr_unit_pkg;

   localparam int unsigned CNTR_WIDTH = 16;
   localparam int unsigned PS_WIDTH   = 4;

   localparam int unsigned TMR_EN_BIT   = 0;
   localparam int unsigned TMR_AUTO_BIT = 1;
   localparam int unsigned TMR_CLR_BIT  = 2;
   localparam int unsigned TMR_PS_LSB   = 4;
   localparam int unsigned TMR_PS_MSB   = 7;
   localparam int unsigned TMR_CMP_LSB  = 16;
   localparam int unsigned TMR_CMP_MSB  = 31;

   typedef enum logic [1:0] {
      TMR_IDLE = 2'd0,
      TMR_RUN  = 2'd1,
      TMR_HALT = 2'd2
   } tmr_state_e;

endpackage

// File: rtl/tmr_unit_if.sv
// CPU <-> timer register-file interface. The tmr_irq signal exists only with TMR_IRQ_EN.
interface tmr_unit_if;

   logic [31:0] tmr_ctrl;
   logic [15:0] tmr_cntr;
   logic        tmr_overflow;
`ifdef TMR_IRQ_EN
   logic        tmr_irq;
`endif

   modport master (
      output tmr_ctrl,
`ifdef TMR_IRQ_EN
      input  tmr_irq,
`endif
      input  tmr_cntr,
      input  tmr_overflow
   );

   modport slave (
      input  tmr_ctrl,
`ifdef TMR_IRQ_EN
      output tmr_irq,
`endif
      output tmr_cntr,
      output tmr_overflow
   );

endinterface

// File: rtl/tmr_unit_prescaler.sv
// Free-running 2^PS clock divider emitting a one-cycle tick; restarts on clr or a PS change.
module tmr_prescaler #(
   parameter int unsigned PS_WIDTH = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic [PS_WIDTH-1:0] ps,
   output logic                tick
);

   localparam int unsigned DivWidth = (1 << PS_WIDTH) - 1;

   logic [DivWidth-1:0] div_q, div_d, div_mask;
   logic [PS_WIDTH-1:0] ps_q;
   logic                ps_change;

   always_comb begin
      div_mask = '0;
      for (int i = 0; i < int'(DivWidth); i++) begin
         div_mask[i] = (i < int'(ps));
      end
      ps_change = (ps != ps_q);
      // A PS change restarts the period, so no stale tick escapes in that cycle.
      tick      = ~clr & ~ps_change & (div_q == div_mask);
      div_d     = (clr | ps_change | tick) ? '0 : div_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q <= '0;
         ps_q  <= '0;
      end else begin
         div_q <= div_d;
         ps_q  <= ps;
      end
   end

endmodule

// File: rtl/tmr_unit.sv
// Compare-match timer: counts prescaled ticks up to CMP, sticky overflow flag.
// Optional one-cycle match pulse tmr_irq when TMR_IRQ_EN is defined.
module tmr_unit
   import tmr_unit_pkg::*;
#(
   parameter int unsigned CNTR_WIDTH = 16,
   parameter int unsigned PS_WIDTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   tmr_unit_if.slave  bus
);

   tmr_state_e          state_q, state_d;
   logic [CNTR_WIDTH-1:0] cntr_q, cntr_d;
   logic                ovf_q, ovf_d;
   logic                clr_q, clr_edge;
   logic                en, auto_rld, tick, match;
   logic [PS_WIDTH-1:0] ps;
   logic [CNTR_WIDTH-1:0] cmp;
   logic                unused_ctrl;

   assign en          = bus.tmr_ctrl[TMR_EN_BIT];
   assign auto_rld    = bus.tmr_ctrl[TMR_AUTO_BIT];
   assign ps          = bus.tmr_ctrl[TMR_PS_MSB:TMR_PS_LSB];
   assign cmp         = bus.tmr_ctrl[TMR_CMP_MSB:TMR_CMP_LSB];
   assign clr_edge    = bus.tmr_ctrl[TMR_CLR_BIT] & ~clr_q;
   assign unused_ctrl = ^{bus.tmr_ctrl[15:8], bus.tmr_ctrl[3]};

   tmr_prescaler #(
      .PS_WIDTH (PS_WIDTH)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   ((state_q != TMR_RUN) | clr_edge),
      .ps    (ps),
      .tick  (tick)
   );

   assign match = tick & (cntr_q == cmp);

   always_comb begin
      state_d = state_q;
      cntr_d  = cntr_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         TMR_IDLE: begin
            if (en) state_d = TMR_RUN;
         end
         TMR_RUN: begin
            if (!en) begin
               state_d = TMR_IDLE;
            end else if (match) begin
               ovf_d = 1'b1;
               if (auto_rld) cntr_d  = '0;
               else          state_d = TMR_HALT;
            end else if (tick) begin
               cntr_d = cntr_q + 1'b1;
            end
         end
         TMR_HALT: begin
            if (clr_edge)  state_d = en ? TMR_RUN : TMR_IDLE;
            else if (!en)  state_d = TMR_IDLE;
         end
         default: state_d = TMR_IDLE;
      endcase
      // Clear wins over any tick or match in the same cycle.
      if (clr_edge) begin
         cntr_d = '0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= TMR_IDLE;
         cntr_q  <= '0;
         ovf_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cntr_q  <= cntr_d;
         ovf_q   <= ovf_d;
         clr_q   <= bus.tmr_ctrl[TMR_CLR_BIT];
      end
   end

   assign bus.tmr_cntr     = cntr_q;
   assign bus.tmr_overflow = ovf_q;

`ifdef TMR_IRQ_EN
   logic irq_q, irq_d;

   // match is already gated off by a coincident clear edge inside the prescaler.
   assign irq_d = (state_q == TMR_RUN) & en & match;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) irq_q <= 1'b0;
      else        irq_q <= irq_d;
   end

   assign bus.tmr_irq = irq_q;
`endif

endmodule

// File: doc/tmr_unit.md
Name: tmr_unit

Overview:
- Hardware timer peripheral on the opposite end of the CPU timer interface.
- The register file drives the level control word `tmr_ctrl`.
- The block counts prescaled clock ticks against a compare value and returns the live count `tmr_cntr` plus a sticky `tmr_overflow` flag, which software reads back through the register file.
- Sits beside the datapath at top level, clocked by the CPU clock.

Parameters:
- CNTR_WIDTH, 16, counter and compare width; fixed to the `tmr_cntr` port width.
- PS_WIDTH, 4, width of the prescaler select field; maximum divide is 2^(2^PS_WIDTH - 1).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- tmr_ctrl  input  32  control word from the register file. Fields:
  - [0] EN
  - [1] AUTO (auto-reload)
  - [2] CLR (rising edge = clear command)
  - [7:4] PS (prescaler select)
  - [31:16] CMP (compare value)
  - all other bits ignored
- tmr_cntr  output  16  current counter value, registered.
- tmr_overflow  output  1  sticky match flag, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - tmr_cntr=0, tmr_overflow=0
  - prescaler count=0, CLR edge register=0, PS history=0
  - state=IDLE
- Prescaler:
  - Free count, cleared whenever state!=RUN, on a CLR edge, or when PS differs from its previous-cycle value.
  - Tick is a single-cycle strobe every 2^PS clocks in RUN. PS=0 gives a tick every cycle.
- CLR edge: clr_q registers tmr_ctrl[2]; an edge is tmr_ctrl[2] & ~clr_q.
- States:
  - IDLE: counter holds. EN=1 -> RUN on the next edge.
  - RUN:
    - EN=0 -> IDLE; counter holds (pause, no clear).
    - On a tick with tmr_cntr==CMP: tmr_overflow<=1. Then either tmr_cntr<=0 and stay in RUN (AUTO=1), or hold tmr_cntr and go to HALT (AUTO=0).
    - On a tick without a match: tmr_cntr<=tmr_cntr+1, wrapping 0xFFFF->0 without setting the flag.
  - HALT: counter frozen. EN=0 -> IDLE. A CLR edge -> RUN if EN=1, else IDLE.
- CLR edge in any state:
  - tmr_cntr<=0, tmr_overflow<=0, prescaler<=0.
  - Takes priority over a tick or match in the same cycle.
- Latency:
  - Counter and flag update on the clock edge ending the tick cycle.
  - First tick occurs 2^PS cycles after entering RUN.
- Period is (CMP+1)*2^PS clocks. CMP=0 with AUTO gives a match on every tick; the flag sets on the first one.
- tmr_overflow is sticky: only reset or a CLR edge clears it. Repeated matches leave it at 1.
- CMP or AUTO change mid-run takes effect immediately. If tmr_cntr>new CMP, counting continues through the wrap to reach CMP.
- Simultaneous EN falling and tick in RUN: the tick is ignored and the state goes to IDLE.

Optional Feature:
- Macro `TMR_IRQ_EN`.
- Defined: adds output port tmr_irq (1 bit, reset 0). It is a one-cycle pulse, registered, asserted in the cycle after each match, including matches while tmr_overflow is already set. It is suppressed if a CLR edge coincides with the match.
- Undefined: no tmr_irq port and no pulse logic. All other behaviour is identical.

Decomposition:
- Shared package/include `timer_defs`:
  - field positions TMR_EN_BIT=0, TMR_AUTO_BIT=1, TMR_CLR_BIT=2, TMR_PS_LSB=4, TMR_PS_MSB=7, TMR_CMP_LSB=16, TMR_CMP_MSB=31
  - state encodings TMR_IDLE=2'd0, TMR_RUN=2'd1, TMR_HALT=2'd2
- One sub-module, `tmr_prescaler`:
  - inputs clk, reset, clr, ps
  - output tick
  - contains the 2^PS divider and the PS change detection.

Test Plan:
- Reset mid-count: pulse reset low while tmr_cntr=5 -> tmr_cntr=0 and tmr_overflow=0 asynchronously; state returns to IDLE.
- EN=1, AUTO=1, PS=0, CMP=3 -> tmr_cntr sequence 0,1,2,3,0,1…; tmr_overflow rises on the edge where cntr 3->0 (4 clocks after RUN entry) and stays 1.
- EN=1, AUTO=0, PS=2, CMP=2 -> counter increments every 4 clocks, freezes at 2, flag=1. A CLR rising edge then gives cntr=0, flag=0, and counting restarts.
- PS=1, CMP=0x0010, count to 7, drop EN for 10 cycles, raise EN -> cntr holds at 7 throughout, then resumes at 8 two clocks after re-entry.
- CLR edge coincident with a match tick (CMP=1, AUTO=1) -> cntr=0, flag stays 0; with TMR_IRQ_EN defined, no tmr_irq pulse.
- CMP lowered from 0x0100 to 0x0002 while cntr=0x0050, PS=0 -> counter runs to 0xFFFF, wraps to 0 with no flag, then matches at 2 and the flag sets.
